// File: rtl/mux4_1.sv
// 4-to-1 multiplexer: combinational output plus a registered copy,
// the select captured alongside it, and a one-cycle change strobe.
module mux4_1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       S,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_r,
    output logic [1:0]       sel_r,
    output logic             chg
);

    // An unknown select propagates as X in simulation and is a don't-care for synthesis.
    always_comb begin
        out = 'x;
        case (S)
            2'b00:   out = a;
            2'b01:   out = b;
            2'b10:   out = c;
            2'b11:   out = d;
            default: out = 'x;
        endcase
    end

    // The first capture is allowed on the first rising edge after release,
    // so reset is applied directly rather than through a release delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
            sel_r <= '0;
            chg   <= 1'b0;
        end else if (en) begin
            out_r <= out;
            sel_r <= S;
            chg   <= (out != out_r);
        end else begin
            chg   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_1.sv
// Randomized self-checking bench for mux4_1 at WIDTH=1 and WIDTH=8,
// compared against an array-indexed reference model of the mux and its register.
module tb_mux4_1;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] S;
    logic       src1 [4];
    logic [7:0] src8 [4];

    logic       out1, out_r1, chg1;
    logic [1:0] sel_r1;
    logic [7:0] out8, out_r8;
    logic       chg8;
    logic [1:0] sel_r8;

    int n_checks = 0;
    int n_errors = 0;

    // reference state of the registered path
    logic       m_r1, m_chg1, m_chg8;
    logic [7:0] m_r8;
    logic [1:0] m_sel;

    mux4_1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a(src1[0]), .b(src1[1]), .c(src1[2]), .d(src1[3]),
        .S(S), .en(en),
        .out(out1), .out_r(out_r1), .sel_r(sel_r1), .chg(chg1)
    );

    mux4_1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .a(src8[0]), .b(src8[1]), .c(src8[2]), .d(src8[3]),
        .S(S), .en(en),
        .out(out8), .out_r(out_r8), .sel_r(sel_r8), .chg(chg8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r1   = 1'b0;
        m_r8   = '0;
        m_sel  = 2'b00;
        m_chg1 = 1'b0;
        m_chg8 = 1'b0;
    endtask

    task automatic check_comb();
        check("out1", {7'b0, out1}, {7'b0, src1[S]});
        check("out8", out8, src8[S]);
    endtask

    task automatic check_regs();
        check("out_r1", {7'b0, out_r1}, {7'b0, m_r1});
        check("sel_r1", {6'b0, sel_r1}, {6'b0, m_sel});
        check("chg1",   {7'b0, chg1},   {7'b0, m_chg1});
        check("out_r8", out_r8, m_r8);
        check("sel_r8", {6'b0, sel_r8}, {6'b0, m_sel});
        check("chg8",   {7'b0, chg8},   {7'b0, m_chg8});
    endtask

    // Inputs must be stable when called; advances one rising edge and checks.
    task automatic tick();
        logic       n1;
        logic [7:0] n8;
        n1 = src1[S];
        n8 = src8[S];
        @(posedge clk);
        if (rst_n) begin
            if (en) begin
                m_chg1 = (n1 != m_r1);
                m_chg8 = (n8 != m_r8);
                m_r1   = n1;
                m_r8   = n8;
                m_sel  = S;
            end else begin
                m_chg1 = 1'b0;
                m_chg8 = 1'b0;
            end
        end
        #1;
        check_regs();
    endtask

    initial begin : stim
        logic [5:0] v;
        logic [7:0] wide_tab [4];
        rst_n = 1'b0;
        en    = 1'b0;
        S     = 2'b00;
        for (int k = 0; k < 4; k++) begin
            src1[k] = 1'b0;
            src8[k] = '0;
        end
        model_reset();

        #2;
        check_regs();

        // exhaustive WIDTH=1 sweep, S0 fastest, during reset
        for (int unsigned i = 0; i < 64; i++) begin
            v = i[5:0];
            S       = v[1:0];
            src1[0] = v[2];
            src1[1] = v[3];
            src1[2] = v[4];
            src1[3] = v[5];
            for (int k = 0; k < 4; k++) src8[k] = 8'($urandom);
            #5;
            check_comb();
        end
        check_regs();

        // unselected inputs must not disturb out
        S = 2'b10;
        src1[2] = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            v = i[5:0];
            src1[0] = v[0];
            src1[1] = v[1];
            src1[3] = v[2];
            #1;
            check("isolate", {7'b0, out1}, 8'h01);
        end
        src1[2] = 1'b0;
        #1;
        check("isolate_c0", {7'b0, out1}, 8'h00);

        // release reset, then randomized traffic
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            S  = 2'($urandom);
            en = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                src1[k] = ($urandom_range(0, 3) == 0);
                src8[k] = (n % 3 == 0) ? out_r8 : 8'($urandom_range(0, 3));
            end
            #1;
            check_comb();
            tick();
        end

        // reset asserted between edges
        @(negedge clk);
        en = 1'b1;
        S  = 2'b00;
        src1[0] = 1'b1;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_out_r", {7'b0, out_r1}, 8'h00);
        check("rst_sel_r", {6'b0, sel_r1}, 8'h00);
        check("rst_chg",   {7'b0, chg1},   8'h00);
        check("rst_out",   {7'b0, out1},   8'h01);
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
        S = 2'b01;
        src1[1] = 1'b1;
        tick();
        check("rel_out_r", {7'b0, out_r1}, 8'h01);
        check("rel_sel_r", {6'b0, sel_r1}, 8'h01);
        check("rel_chg",   {7'b0, chg1},   8'h01);

        // enable low holds the captured value
        @(negedge clk);
        en = 1'b0;
        S  = 2'b00;
        src1[0] = 1'b0;
        #1;
        check("hold_out", {7'b0, out1}, 8'h00);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("hold_out_r", {7'b0, out_r1}, 8'h01);
            check("hold_sel_r", {6'b0, sel_r1}, 8'h01);
            check("hold_chg",   {7'b0, chg1},   8'h00);
        end

        // change strobe
        @(negedge clk);
        en = 1'b1;
        S  = 2'b01;
        tick();
        tick();
        check("steady_chg", {7'b0, chg1}, 8'h00);
        @(negedge clk);
        src1[1] = 1'b0;
        tick();
        check("flip_chg", {7'b0, chg1}, 8'h01);
        tick();
        check("flip_chg_end", {7'b0, chg1}, 8'h00);

        // wide data
        wide_tab[0] = 8'h11;
        wide_tab[1] = 8'h22;
        wide_tab[2] = 8'h44;
        wide_tab[3] = 8'h88;
        for (int k = 0; k < 4; k++) src8[k] = wide_tab[k];
        for (int unsigned s = 0; s < 4; s++) begin
            @(negedge clk);
            S = s[1:0];
            #1;
            check("wide_out", out8, wide_tab[s]);
            tick();
            check("wide_out_r", out_r8, wide_tab[s]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_errors++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
